// File: rtl/otter_mem_arbiter.sv
`timescale 1ns/1ps
// otter_mem_arbiter
// Sequences the OTTER instruction-fetch refill path (I_*) and the MEM-stage
// load/store path (D_*) onto one REQ/ACK backing-memory port (M_*).
// Data accesses win ties. With OTTER_ARB_STARVE_GUARD_EN defined, a starvation
// counter forces a fetch grant after STARVE_LIMIT data grants made while fetch
// was waiting. Without it, D-over-I priority is strict.
// Ports:
//   CLK, RST                  clock, async active-high reset
//   I_REQ/I_ADDR              fetch request in; I_RDATA/I_VALID completion out
//   D_REQ/D_WE/D_ADDR/D_WDATA/D_SIZE  data request in; D_RDATA/D_VALID out
//   M_REQ/M_WE/M_ADDR/M_WDATA/M_SIZE  registered memory request out
//   M_ACK/M_RDATA             memory completion in
module otter_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic [31:0] I_RDATA,
  output logic        I_VALID,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [1:0]  D_SIZE,
  output logic [31:0] D_RDATA,
  output logic        D_VALID,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [1:0]  M_SIZE,
  input  logic        M_ACK,
  input  logic [31:0] M_RDATA
);

  localparam int unsigned CNT_W = 4;

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("otter_mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t      state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [1:0]  m_size_q, m_size_d;
  logic        i_valid_q, i_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic force_i_c;
  logic grant_i_c;
  logic grant_d_c;

`ifdef OTTER_ARB_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_i_c = (starve_cnt_q == STARVE_MAX);

  // Count data grants that overtook a waiting fetch; any fetch grant clears.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (grant_i_c) begin
        starve_cnt_d = '0;
      end else if (grant_d_c && I_REQ && (starve_cnt_q != STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_i_c = 1'b0;
`endif

  // Grant decision; only consumed in IDLE.
  assign grant_i_c = I_REQ & (~D_REQ | force_i_c);
  assign grant_d_c = D_REQ & ~grant_i_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_size_d  = m_size_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = D_WE;
          m_addr_d  = D_ADDR;
          m_wdata_d = D_WDATA;
          m_size_d  = D_SIZE;
        end else if (grant_i_c) begin
          state_d   = BUSY_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = I_ADDR;
          m_wdata_d = '0;
          m_size_d  = 2'd2;
        end
      end
      BUSY_I: begin
        if (M_ACK) begin
          state_d   = DONE;
          m_req_d   = 1'b0;
          i_valid_d = 1'b1;
          i_rdata_d = M_RDATA;
        end
      end
      BUSY_D: begin
        if (M_ACK) begin
          state_d   = DONE;
          m_req_d   = 1'b0;
          d_valid_d = 1'b1;
          // Stores leave the last load data in place.
          if (!m_we_q) begin
            d_rdata_d = M_RDATA;
          end
        end
      end
      DONE: begin
        // Requests are not sampled here, giving requesters time to retire REQ.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q  <= m_size_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign M_REQ   = m_req_q;
  assign M_WE    = m_we_q;
  assign M_ADDR  = m_addr_q;
  assign M_WDATA = m_wdata_q;
  assign M_SIZE  = m_size_q;
  assign I_VALID = i_valid_q;
  assign D_VALID = d_valid_q;
  assign I_RDATA = i_rdata_q;
  assign D_RDATA = d_rdata_q;

endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Shared-memory-port arbiter for the pipelined OTTER core. It sequences two requesters, the instruction-fetch refill path and the MEM-stage load/store path, onto one backing-memory port that uses a REQ/ACK handshake with variable latency. Data accesses have priority, and a starvation guard bounds how long fetch can wait. It sits between the core's cache/memory front end and the external memory model.

## Interface
- STARVE_LIMIT, 4: consecutive data grants with fetch pending before fetch is forced (1..15).
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- I_REQ  in  1  fetch request; held with I_ADDR stable until I_VALID.
- I_ADDR  in  32  fetch word address.
- I_RDATA  out  32  fetch read data; valid while I_VALID.
- I_VALID  out  1  one-cycle completion pulse for fetch.
- D_REQ  in  1  data request; held with operands stable until D_VALID.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  32  data address.
- D_WDATA  in  32  store data.
- D_SIZE  in  2  0 = byte, 1 = half, 2 = word; passed through.
- D_RDATA  out  32  load data; valid while D_VALID.
- D_VALID  out  1  one-cycle completion pulse for data (loads and stores).
- M_REQ  out  1  memory request; held until M_ACK.
- M_WE, M_ADDR, M_WDATA, M_SIZE  out  1/32/32/2  latched operands of the granted access.
- M_ACK  in  1  memory completion; sampled only while M_REQ=1.
- M_RDATA  in  32  memory read data; valid with M_ACK.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: requests are sampled here only.
  - With no request, remain in IDLE.
  - With only one requester active, grant it.
  - With both active, D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - On a grant, latch operands into M_* (I-side: M_WE=0, M_SIZE=2, M_WDATA=0) and go to BUSY_x.
- BUSY_x: M_REQ=1 and M_* are held stable.
  - On M_ACK: capture M_RDATA into x_RDATA (I always; D only when M_WE=0, D_RDATA unchanged on stores), drop M_REQ, go to DONE.
- DONE: x_VALID=1 for this cycle only. Go to IDLE, ignoring REQ inputs in this cycle.
  - A requester deasserts REQ, or presents new operands, by the edge ending its VALID cycle.
- starve_cnt (4 bits):
  - Increments on each D grant made while I_REQ=1; saturates at STARVE_LIMIT.
  - Clears on every I grant.
  - Unaffected by D grants made while I_REQ=0.
- Reset value of every output is 0: M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, I_VALID, D_VALID, I_RDATA, D_RDATA. The FSM resets to IDLE and starve_cnt to 0.
- RST mid-transaction abandons the in-flight access with no VALID pulse. The memory tolerates M_REQ dropping without ACK.
- M_ACK outside BUSY_x is ignored.

## Timing
- REQ high in IDLE at edge k, so M_REQ=1 from edge k.
- M_ACK high at edge k+n (n ≥ 1), so x_VALID=1 from edge k+n for one cycle, and IDLE from edge k+n+1.
- Minimum latency is REQ to VALID in 2 cycles. Peak throughput is one access per 3 cycles.
- x_RDATA holds its value until the next completion on that side.
- M_* outputs are registered; no combinational path from any REQ to any M_* output.
- I_VALID and D_VALID are never high in the same cycle.

## Configuration
- OTTER_ARB_STARVE_GUARD_EN defined:
  - starve_cnt and the forced-fetch rule exist as described.
  - Fetch waits at most STARVE_LIMIT data accesses.
- OTTER_ARB_STARVE_GUARD_EN undefined:
  - starve_cnt is not built and STARVE_LIMIT is unused.
  - Strict D-over-I priority always applies; fetch can starve under continuous data traffic.

## Test plan
- Reset to 0x0 state: assert RST mid-BUSY_D with M_ACK low -> all outputs 0 immediately, no D_VALID afterwards, next I_REQ granted from IDLE.
- Single fetch: I_REQ, I_ADDR=0x100, memory acks 3 cycles after M_REQ with 0x00500093 -> M_ADDR=0x100, M_WE=0, I_VALID one cycle with I_RDATA=0x00500093, D_VALID stays 0.
- Store then load: D store to 0x6000 with data 0xDEADBEEF and size 2, then load from 0x6000 -> M_WE=1 then 0, D_VALID twice, D_RDATA=0xDEADBEEF only after the load.
- Simultaneous requests (guard on, STARVE_LIMIT=4): I_REQ held high, D_REQ re-issued every completion -> exactly 4 D grants, then 1 I grant, then D resumes with starve_cnt=0.
- Same traffic with macro undefined -> I never granted while D_REQ keeps re-arriving; I is granted the first IDLE cycle D_REQ is low.
- Zero-wait memory (M_ACK tied 1): back-to-back D requests -> D_VALID every 3rd cycle, M_REQ low in each DONE cycle.
